// File: rtl/fifo_frame_scheduler_pkg.sv
// Shared definitions for the FIFO frame scheduler: read-FSM state encoding
// and the default byte width / frame size.
package fifo_frame_scheduler_pkg;

   localparam int DEFAULT_WIDTH       = 8;
   localparam int DEFAULT_READ_SCALAR = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      POP  = 2'd1,
      HOLD = 2'd2
   } rd_state_e;

endpackage

// File: rtl/fifo_frame_scheduler_rr_arbiter2.sv
// Two-requester round-robin write arbiter feeding the FIFO write port.
// The grant and write strobe are combinational; only the round-robin pointer is registered.
module rr_arbiter2 import fifo_frame_scheduler_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   input  logic [WIDTH-1:0] req_data0,
   input  logic [WIDTH-1:0] req_data1,
   input  logic             fifo_full,
   output logic [1:0]       req_ready,
   output logic             fifo_wr_en,
   output logic [WIDTH-1:0] fifo_din
);

   logic rr_ptr_q, rr_ptr_d;
   logic rr_eff;
   logic grant;
   logic any_valid;

   // During reset the pointer is treated as 0 even before the flop clears.
   assign rr_eff    = reset ? 1'b0 : rr_ptr_q;
   assign any_valid = |req_valid;

   always_comb begin
      grant      = 1'b0;
      req_ready  = 2'b00;
      fifo_wr_en = 1'b0;
      fifo_din   = '0;
      rr_ptr_d   = rr_ptr_q;
      case (req_valid)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = rr_eff;
         default: grant = 1'b0;
      endcase
      if (any_valid) begin
         req_ready[grant] = !fifo_full;
         fifo_wr_en       = !fifo_full;
         fifo_din         = grant ? req_data1 : req_data0;
      end
      if (fifo_wr_en) rr_ptr_d = !grant;
   end

   always_ff @(posedge clk) begin
      if (reset) rr_ptr_q <= 1'b0;
      else       rr_ptr_q <= rr_ptr_d;
   end

endmodule

// File: rtl/fifo_frame_scheduler.sv
// Frame scheduler: arbitrates two byte requesters into a FIFO and pops
// READ_SCALAR-byte frames out to a valid/ready port with a completion counter.
module fifo_frame_scheduler import fifo_frame_scheduler_pkg::*; #(
   parameter int WIDTH       = DEFAULT_WIDTH,
   parameter int READ_SCALAR = DEFAULT_READ_SCALAR,
   parameter int CNT_W       = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         enable,
   input  logic [1:0]                   req_valid,
   input  logic [WIDTH-1:0]             req_data0,
   input  logic [WIDTH-1:0]             req_data1,
   output logic [1:0]                   req_ready,
   output logic                         fifo_wr_en,
   output logic [WIDTH-1:0]             fifo_din,
   input  logic                         fifo_full,
   output logic                         fifo_rd_en,
   input  logic [WIDTH*READ_SCALAR-1:0] fifo_dout,
   input  logic                         fifo_empty,
   output logic                         frame_valid,
   output logic [WIDTH*READ_SCALAR-1:0] frame_data,
   input  logic                         frame_ready,
   output logic [CNT_W-1:0]             frame_count,
   output logic                         busy
);

   rd_state_e                    state_q, state_d;
   logic [WIDTH*READ_SCALAR-1:0] frame_data_q, frame_data_d;
   logic [CNT_W-1:0]             frame_count_q, frame_count_d;
   logic                         pop_ok;

   rr_arbiter2 #(.WIDTH(WIDTH)) u_arb (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data0  (req_data0),
      .req_data1  (req_data1),
      .fifo_full  (fifo_full),
      .req_ready  (req_ready),
      .fifo_wr_en (fifo_wr_en),
      .fifo_din   (fifo_din)
   );

   assign pop_ok = enable && !fifo_empty;

   always_comb begin
      state_d       = state_q;
      frame_data_d  = frame_data_q;
      frame_count_d = frame_count_q;
      case (state_q)
         IDLE: if (pop_ok) state_d = POP;
         POP: begin
            if (!fifo_empty) begin
               frame_data_d = fifo_dout;
               state_d      = HOLD;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (frame_ready) begin
               frame_count_d = frame_count_q + CNT_W'(1);
               state_d       = pop_ok ? POP : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are masked while reset is asserted so a frame in flight is dropped at once.
   assign fifo_rd_en  = !reset && (state_q == POP) && !fifo_empty;
   assign frame_valid = !reset && (state_q == HOLD);
   assign busy        = !reset && (state_q != IDLE);
   assign frame_data  = frame_data_q;
   assign frame_count = frame_count_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         frame_data_q  <= '0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         frame_data_q  <= frame_data_d;
         frame_count_q <= frame_count_d;
      end
   end

endmodule

// File: tb/tb_fifo_frame_scheduler.sv
// Directed bench for fifo_frame_scheduler; FIFO flags and frame view are driven directly.
// The counter is built 8 bits wide so the wrap case runs in a few hundred cycles.
module tb_fifo_frame_scheduler;
   import fifo_frame_scheduler_pkg::*;

   localparam int WIDTH = 8;
   localparam int RS    = 11;
   localparam int FW    = WIDTH * RS;
   localparam int CNT_W = 8;

   localparam logic [FW-1:0] PAT_A = 88'h0102030405060708090A0B;
   localparam logic [FW-1:0] PAT_B = 88'hF1F2F3F4F5F6F7F8F9FAFB;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [1:0]       req_valid;
   logic [WIDTH-1:0] req_data0, req_data1;
   logic [1:0]       req_ready;
   logic             fifo_wr_en;
   logic [WIDTH-1:0] fifo_din;
   logic             fifo_full;
   logic             fifo_rd_en;
   logic [FW-1:0]    fifo_dout;
   logic             fifo_empty;
   logic             frame_valid;
   logic [FW-1:0]    frame_data;
   logic             frame_ready;
   logic [CNT_W-1:0] frame_count;
   logic             busy;

   int               n_cmp = 0;
   int               n_err = 0;
   logic [CNT_W-1:0] exp_count;

   fifo_frame_scheduler #(.WIDTH(WIDTH), .READ_SCALAR(RS), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .req_valid   (req_valid),
      .req_data0   (req_data0),
      .req_data1   (req_data1),
      .req_ready   (req_ready),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_din    (fifo_din),
      .fifo_full   (fifo_full),
      .fifo_rd_en  (fifo_rd_en),
      .fifo_dout   (fifo_dout),
      .fifo_empty  (fifo_empty),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_ready (frame_ready),
      .frame_count (frame_count),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b0; req_valid = 2'b00; req_data0 = 8'hA0; req_data1 = 8'hB0;
      fifo_full = 1'b0; fifo_dout = '0; fifo_empty = 1'b1; frame_ready = 1'b0;
      step(); step();
      req_valid = 2'b11;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 01", req_ready); end
      n_cmp++; if (fifo_din !== 8'hA0) begin n_err++; $display("[TB] FAIL reset_din: got %h want a0", fifo_din); end
      n_cmp++; if ({frame_valid, fifo_rd_en, busy} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_outs: got %b want 000", {frame_valid, fifo_rd_en, busy}); end
      req_valid = 2'b00;
      step();
      reset = 1'b0;
      #1;
      n_cmp++; if (frame_count !== 8'h00) begin n_err++; $display("[TB] FAIL reset_count: got %h want 00", frame_count); end
      n_cmp++; if (frame_data !== '0) begin n_err++; $display("[TB] FAIL reset_data: got %h want 0", frame_data); end
      n_cmp++; if ({frame_valid, busy} !== 2'b00) begin n_err++; $display("[TB] FAIL post_reset_outs: got %b want 00", {frame_valid, busy}); end
      exp_count = '0;
   endtask

   task automatic test_alternate();
      logic [7:0] exp_din;
      logic [1:0] exp_rdy;
      step();
      req_data0 = 8'hA0; req_data1 = 8'hB0; req_valid = 2'b11;
      for (int i = 0; i < 6; i++) begin
         exp_din = ((i % 2) == 0) ? 8'(8'hA0 + i / 2) : 8'(8'hB0 + i / 2);
         exp_rdy = ((i % 2) == 0) ? 2'b01 : 2'b10;
         #1;
         n_cmp++; if (fifo_wr_en !== 1'b1) begin n_err++; $display("[TB] FAIL alt_wr_en[%0d]: got %b want 1", i, fifo_wr_en); end
         n_cmp++; if (fifo_din !== exp_din) begin n_err++; $display("[TB] FAIL alt_din[%0d]: got %h want %h", i, fifo_din, exp_din); end
         n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("[TB] FAIL alt_ready[%0d]: got %b want %b", i, req_ready, exp_rdy); end
         step();
         if ((i % 2) == 0) req_data0 = req_data0 + 8'h01;
         else              req_data1 = req_data1 + 8'h01;
      end
   endtask

   task automatic test_full();
      fifo_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_cmp++; if ({req_ready, fifo_wr_en} !== 3'b000) begin n_err++; $display("[TB] FAIL full_block[%0d]: got %b want 000", i, {req_ready, fifo_wr_en}); end
         step();
      end
      fifo_full = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL full_resume_ready: got %b want 01", req_ready); end
      n_cmp++; if (fifo_din !== 8'hA3) begin n_err++; $display("[TB] FAIL full_resume_din: got %h want a3", fifo_din); end
      step();
      req_valid = 2'b10;
      #1;
      n_cmp++; if ({req_ready, fifo_din} !== {2'b10, 8'hB3}) begin n_err++; $display("[TB] FAIL sole1: got %b/%h want 10/b3", req_ready, fifo_din); end
      step();
      req_valid = 2'b11;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL ptr_after_sole1: got %b want 01", req_ready); end
      req_valid = 2'b00;
      #1;
      n_cmp++; if ({req_ready, fifo_wr_en, fifo_din} !== 11'd0) begin n_err++; $display("[TB] FAIL none_valid: got %b/%b/%h want 00/0/00", req_ready, fifo_wr_en, fifo_din); end
   endtask

   task automatic test_read_latency();
      enable = 1'b1; fifo_empty = 1'b1; frame_ready = 1'b0;
      step();
      #1;
      n_cmp++; if ({fifo_rd_en, busy} !== 2'b00) begin n_err++; $display("[TB] FAIL idle_empty: got %b want 00", {fifo_rd_en, busy}); end
      fifo_empty = 1'b0; fifo_dout = PAT_A;
      #1;
      n_cmp++; if (fifo_rd_en !== 1'b0) begin n_err++; $display("[TB] FAIL idle_no_rd: got %b want 0", fifo_rd_en); end
      step();
      #1;
      n_cmp++; if ({fifo_rd_en, busy, frame_valid} !== 3'b110) begin n_err++; $display("[TB] FAIL pop_pulse: got %b want 110", {fifo_rd_en, busy, frame_valid}); end
      step();
      fifo_dout = PAT_B;
      #1;
      n_cmp++; if ({frame_valid, fifo_rd_en} !== 2'b10) begin n_err++; $display("[TB] FAIL hold_valid: got %b want 10", {frame_valid, fifo_rd_en}); end
      n_cmp++; if (frame_data !== PAT_A) begin n_err++; $display("[TB] FAIL hold_data: got %h want %h", frame_data, PAT_A); end
   endtask

   task automatic test_hold_stall();
      for (int i = 0; i < 10; i++) begin
         #1;
         n_cmp++; if ({frame_valid, fifo_rd_en} !== 2'b10 || frame_data !== PAT_A || frame_count !== exp_count) begin
            n_err++; $display("[TB] FAIL stall[%0d]: got v/rd=%b data=%h cnt=%h want 10/%h/%h", i, {frame_valid, fifo_rd_en}, frame_data, frame_count, PAT_A, exp_count);
         end
         step();
      end
      frame_ready = 1'b1;
      step();
      exp_count = exp_count + 8'h01;
      frame_ready = 1'b0;
      #1;
      n_cmp++; if (frame_count !== exp_count) begin n_err++; $display("[TB] FAIL stall_count: got %h want %h", frame_count, exp_count); end
      n_cmp++; if ({fifo_rd_en, frame_valid} !== 2'b10) begin n_err++; $display("[TB] FAIL handshake_to_pop: got %b want 10", {fifo_rd_en, frame_valid}); end
      step();
      #1;
      n_cmp++; if (frame_data !== PAT_B) begin n_err++; $display("[TB] FAIL second_frame: got %h want %h", frame_data, PAT_B); end
      enable = 1'b0; frame_ready = 1'b1;
      step();
      exp_count = exp_count + 8'h01;
      frame_ready = 1'b0;
      #1;
      n_cmp++; if ({busy, fifo_rd_en, frame_count} !== {2'b00, exp_count}) begin n_err++; $display("[TB] FAIL hold_to_idle: got %b/%h want 00/%h", {busy, fifo_rd_en}, frame_count, exp_count); end
   endtask

   task automatic test_pop_empty();
      enable = 1'b1; fifo_empty = 1'b0;
      step();
      fifo_empty = 1'b1;
      #1;
      n_cmp++; if ({fifo_rd_en, busy} !== 2'b01) begin n_err++; $display("[TB] FAIL pop_empty: got %b want 01", {fifo_rd_en, busy}); end
      step();
      #1;
      n_cmp++; if ({busy, frame_valid} !== 2'b00) begin n_err++; $display("[TB] FAIL pop_empty_idle: got %b want 00", {busy, frame_valid}); end
      fifo_empty = 1'b0; fifo_dout = PAT_A;
      step();
      enable = 1'b0;
      #1;
      n_cmp++; if (fifo_rd_en !== 1'b1) begin n_err++; $display("[TB] FAIL enable_drop_pop: got %b want 1", fifo_rd_en); end
      step();
      #1;
      n_cmp++; if ({frame_valid, frame_data} !== {1'b1, PAT_A}) begin n_err++; $display("[TB] FAIL enable_drop_hold: got %b/%h want 1/%h", frame_valid, frame_data, PAT_A); end
      frame_ready = 1'b1;
      step();
      exp_count = exp_count + 8'h01;
      frame_ready = 1'b0;
      #1;
      n_cmp++; if ({busy, frame_count} !== {1'b0, exp_count}) begin n_err++; $display("[TB] FAIL enable_drop_done: got %b/%h want 0/%h", busy, frame_count, exp_count); end
   endtask

   task automatic test_back_to_back();
      enable = 1'b1; fifo_empty = 1'b0; frame_ready = 1'b1; req_valid = 2'b01; req_data0 = 8'hC0;
      step();
      for (int i = 0; i < 6; i++) begin
         #1;
         n_cmp++; if ({fifo_rd_en, frame_valid, fifo_wr_en} !== {((i % 2) == 0), ((i % 2) == 1), 1'b1}) begin
            n_err++; $display("[TB] FAIL b2b[%0d]: got rd/v/wr=%b want %b%b1", i, {fifo_rd_en, frame_valid, fifo_wr_en}, ((i % 2) == 0), ((i % 2) == 1));
         end
         step();
         if ((i % 2) == 1) exp_count = exp_count + 8'h01;
      end
      #1;
      n_cmp++; if (frame_count !== exp_count) begin n_err++; $display("[TB] FAIL b2b_count: got %h want %h", frame_count, exp_count); end
      enable = 1'b0; fifo_empty = 1'b1; frame_ready = 1'b0; req_valid = 2'b00;
      step();
   endtask

   task automatic test_wrap();
      int n;
      n = 255 - int'(exp_count);
      enable = 1'b1; fifo_empty = 1'b0; frame_ready = 1'b1;
      repeat (1 + 2 * n) step();
      #1;
      n_cmp++; if (frame_count !== 8'hFF) begin n_err++; $display("[TB] FAIL wrap_pre: got %h want ff", frame_count); end
      repeat (4) step();
      exp_count = 8'h01;
      #1;
      n_cmp++; if (frame_count !== exp_count) begin n_err++; $display("[TB] FAIL wrap: got %h want 01", frame_count); end
      enable = 1'b0; fifo_empty = 1'b1; frame_ready = 1'b0;
      step();
   endtask

   task automatic test_reset_in_hold();
      enable = 1'b1; fifo_empty = 1'b0; fifo_dout = PAT_B; frame_ready = 1'b0;
      step(); step();
      #1;
      n_cmp++; if (frame_valid !== 1'b1) begin n_err++; $display("[TB] FAIL rih_setup: got %b want 1", frame_valid); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({frame_valid, fifo_rd_en, busy} !== 3'b000) begin n_err++; $display("[TB] FAIL rih_during: got %b want 000", {frame_valid, fifo_rd_en, busy}); end
      step();
      reset = 1'b0;
      exp_count = '0;
      #1;
      n_cmp++; if ({frame_valid, fifo_rd_en, busy, frame_count} !== {3'b000, exp_count}) begin
         n_err++; $display("[TB] FAIL rih_after: got %b/%h want 000/00", {frame_valid, fifo_rd_en, busy}, frame_count);
      end
      n_cmp++; if (frame_data !== '0) begin n_err++; $display("[TB] FAIL rih_data: got %h want 0", frame_data); end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_full();
      test_read_latency();
      test_hold_stall();
      test_pop_empty();
      test_back_to_back();
      test_wrap();
      test_reset_in_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
